// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: captures two operands and a carry-in, then runs
// one bit pair per cycle through a single full-adder cell, LSB first.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] partial;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_bit;
    logic             last_bit;
    logic             accept;

    // The shared full-adder cell.
    assign s_bit    = areg[0] ^ breg[0] ^ carry;
    assign c_bit    = (areg[0] & breg[0]) | (areg[0] & carry) | (breg[0] & carry);
    assign last_bit = (cnt == LAST_BIT);
    assign accept   = (state == IDLE) && start;

    // Moore outputs decoded straight from the state register.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block purely
    // combinational; a missing branch would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            areg    <= '0;
            breg    <= '0;
            partial <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            areg    <= a;
            breg    <= b;
            partial <= '0;
            carry   <= cin;
            cnt     <= '0;
        end else if (state == SHIFT) begin
            areg    <= areg >> 1;
            breg    <= breg >> 1;
            partial <= {s_bit, partial[WIDTH-1:1]};
            carry   <= c_bit;
            cnt     <= cnt + 1'b1;
            // Result registers update only on the final bit, never mid-add.
            if (last_bit) begin
                sum  <= {s_bit, partial[WIDTH-1:1]};
                cout <= c_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random bench for serial_add_ctrl at WIDTH=8; inputs are driven
// and outputs sampled on the falling edge.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Steps until done is seen; n is the number of edges waited.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic [W:0] exp);
        int n;
        a = ta; b = tb; cin = tc; start = 1'b1;
        step();
        start = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc;
        wait_done(tag, n);
        check({tag, "_lat"}, n, W);
        check({tag, "_res"}, {cout, sum}, exp);
        step();
        check({tag, "_pulse"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int n;
        int gap;
        int bc;
        logic hold_ok;
        logic [W-1:0] ra, rb;
        logic rc;

        // 1: reset, then a basic add
        step(); step();
        rst = 1'b0;
        check("rst_state", {busy, done, cout, sum}, '0);
        run_op("t1", 8'h5A, 8'h3C, 1'b0, 9'h096);

        // 2: carry propagation
        run_op("t2a", 8'hFF, 8'h01, 1'b0, 9'h100);
        run_op("t2b", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

        // 3: start while busy is ignored and not queued
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        a = 8'h77; b = 8'h11; start = 1'b1;
        step();
        start = 1'b0;
        check("t3_busy_mid", busy, 1'b1);
        wait_done("t3", n);
        check("t3_lat", n, W - 3);
        check("t3_res", {cout, sum}, 9'h030);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t3_drop", {busy, done}, 2'b00);
        step();
        check("t3_noq", {busy, done}, 2'b00);
        step();
        check("t3_hold", {cout, sum}, 9'h030);

        // 4: reset aborts an operation
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_abort", {busy, done, cout, sum}, '0);
        n = 0;
        repeat (10) begin
            step();
            if (done || busy) n++;
        end
        check("t4_nodone", n, 0);
        run_op("t4", 8'h0F, 8'h01, 1'b0, 9'h010);

        // 5: start held high, back-to-back operations
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        step();
        a = 8'h80; b = 8'h80;
        wait_done("t5a", n);
        check("t5a_res", {cout, sum}, 9'h002);
        n = 0;
        hold_ok = 1'b1;
        step();
        n++;
        while (!done && n < 40) begin
            if ({cout, sum} !== 9'h002) hold_ok = 1'b0;
            step();
            n++;
        end
        check("t5_hold", hold_ok, 1'b1);
        check("t5_gap", n, 10);
        check("t5b_res", {cout, sum}, 9'h100);
        start = 1'b0;
        step(); step();

        // 6: random regression
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            a = ra; b = rb; cin = rc; start = 1'b1;
            step();
            start = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            bc = 0;
            while (busy && bc < 40) begin
                bc++;
                if (done) check("t6_res", {cout, sum}, {1'b0, ra} + {1'b0, rb} + (W+1)'(rc));
                step();
            end
            check("t6_busy", bc, W + 1);
            gap = $urandom_range(0, 3);
            repeat (gap) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial addition sequencer. It captures two WIDTH-bit operands and a carry-in on a start request. It then feeds one bit pair per cycle through a single full-adder cell, keeping the carry in a flip-flop between cycles. It reports the registered sum and carry-out with a one-cycle done pulse. It sits between a requesting control unit and a shared 1-bit full-adder datapath, trading area for latency.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32)

Ports:
clk    input   1      system clock; all state updates on posedge
rst    input   1      synchronous, active-high reset
start  input   1      request; sampled only in IDLE
a      input   WIDTH  operand A; captured on accepted start
b      input   WIDTH  operand B; captured on accepted start
cin    input   1      carry-in; captured on accepted start
busy   output  1      high whenever state != IDLE
done   output  1      one-cycle pulse; result valid
sum    output  WIDTH  registered result; changes only on completion
cout   output  1      registered final carry; changes only on completion

Behaviour:
- Reset (rst=1 at posedge) forces the following, regardless of state:
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry flip-flop and bit counter cleared.
- Reset overrides start in the same cycle.
- Reset mid-operation aborts the addition; no done pulse is produced.
- States: IDLE, SHIFT, DONE (Moore outputs; busy and done decoded from registered state).
- IDLE:
  - start=1 at posedge E0 loads areg<=a, breg<=b, carry<=cin, cnt<=0, state<=SHIFT.
  - start=0: remain in IDLE.
- SHIFT, one bit per posedge:
  - s_bit = areg[0]^breg[0]^carry.
  - c_bit = majority(areg[0], breg[0], carry).
  - carry<=c_bit.
  - areg and breg shift right by 1, zero-filled.
  - Partial-sum register shifts right, with s_bit entering at bit WIDTH-1.
  - cnt<=cnt+1.
- SHIFT exit: on the posedge where cnt==WIDTH-1 (edge E_WIDTH), the final bit is processed and:
  - sum<={s_bit, partial[WIDTH-1:1]}.
  - cout<=c_bit.
  - state<=DONE.
- DONE: done=1 for exactly one cycle; next posedge state<=IDLE.
- Latency: start sampled at E0 → done high from E_WIDTH to E_WIDTH+1.
- Minimum start-to-start period: WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored; it is not queued.
- A start held high continuously is accepted on the first IDLE cycle after DONE.
- a, b and cin may change freely after acceptance; the operation uses the captured values.
- sum and cout hold their last result from completion until the next completion or reset. They never expose partial values.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); exact, no overflow loss.
- cnt width is clog2(WIDTH); it is never compared beyond WIDTH-1.

Test Plan:
1. WIDTH=8, rst for 2 cycles → busy=0, done=0, sum=0x00, cout=0. Then start with a=0x5A, b=0x3C, cin=0 → done pulses 8 edges after acceptance, lasting 1 cycle; sum=0x96, cout=0.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1 (carry ripples through all bits).
3. Accept a=0x10, b=0x20. Assert start with a=0x77, b=0x11 on SHIFT cycle 3 and again during DONE → first result sum=0x30 only; no second done; busy drops 1 cycle after done.
4. Accept a=0x0F, b=0x01, then raise rst after 4 shift cycles → next cycle busy=0, sum=0, cout=0, no done. New start with a=0x0F, b=0x01 → sum=0x10, cout=0.
5. start held high, two ops (0x01+0x01, then 0x80+0x80) → second op accepted on the IDLE cycle after done. sum holds 0x02 until the second done, then becomes 0x00 with cout=1. Exactly 10 cycles between done pulses.
6. Random regression: 1000 random a, b, cin with random start gaps → {cout,sum} == a+b+cin at every done. busy==1 exactly WIDTH+1 cycles per operation.
